// File: rtl/periodic_framer_pkg.sv
// Shared types and constants for the multi-lane periodic framer.
package periodic_framer_pkg;

  // Framer FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OFFSET = 2'd1,
    FRAME  = 2'd2,
    GAP    = 2'd3
  } state_e;

  // Settings register offsets from the base address
  localparam logic [7:0] REG_FRAME_LEN  = 8'd0;
  localparam logic [7:0] REG_GAP_LEN    = 8'd1;
  localparam logic [7:0] REG_OFFSET     = 8'd2;
  localparam logic [7:0] REG_MAX_FRAMES = 8'd3;
  localparam logic [7:0] REG_LANE_MASK  = 8'd4;
  localparam logic [7:0] REG_ABORT      = 8'd5;

  // Reset defaults of the framing registers (lane mask resets to all ones)
  localparam int unsigned DEF_FRAME_LEN  = 64;
  localparam int unsigned DEF_GAP_LEN    = 16;
  localparam int unsigned DEF_OFFSET     = 0;
  localparam int unsigned DEF_MAX_FRAMES = 1;

  // A zero length behaves as a length of one; returns the terminal count
  function automatic logic [15:0] len_to_last(input logic [15:0] len);
    return (len == 16'd0) ? 16'd0 : len - 16'd1;
  endfunction

endpackage

// File: rtl/framer_settings_regs.sv
// Settings bus decode with live registers and burst-time shadow copies.
module framer_settings_regs
  import periodic_framer_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned CNT_W   = 16,
  parameter logic [7:0]  SR_BASE = 8'h10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              set_stb_i,
  input  logic [7:0]        set_addr_i,
  input  logic [31:0]       set_data_i,
  input  logic              load_i,
  output logic [CNT_W-1:0]  frame_len_o,
  output logic [CNT_W-1:0]  gap_len_o,
  output logic [CNT_W-1:0]  offset_o,
  output logic [7:0]        max_frames_o,
  output logic [NUM_CH-1:0] lane_mask_o,
  output logic [CNT_W-1:0]  sh_frame_len_o,
  output logic [CNT_W-1:0]  sh_gap_len_o,
  output logic [CNT_W-1:0]  sh_offset_o,
  output logic [7:0]        sh_max_frames_o,
  output logic [NUM_CH-1:0] sh_lane_mask_o,
  output logic              abort_o
);

  logic [7:0]        reg_off;
  logic [CNT_W-1:0]  frame_len_q, gap_len_q, offset_q;
  logic [7:0]        max_frames_q;
  logic [NUM_CH-1:0] lane_mask_q;
  logic [CNT_W-1:0]  sh_frame_len_q, sh_gap_len_q, sh_offset_q;
  logic [7:0]        sh_max_frames_q;
  logic [NUM_CH-1:0] sh_lane_mask_q;
  logic              unused_data;

  assign reg_off     = set_addr_i - SR_BASE;
  assign abort_o     = set_stb_i && (reg_off == REG_ABORT);
  assign unused_data = ^set_data_i;

  // Live registers, written straight from the settings bus
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_len_q  <= CNT_W'(DEF_FRAME_LEN);
      gap_len_q    <= CNT_W'(DEF_GAP_LEN);
      offset_q     <= CNT_W'(DEF_OFFSET);
      max_frames_q <= 8'(DEF_MAX_FRAMES);
      lane_mask_q  <= '1;
    end else if (set_stb_i) begin
      case (reg_off)
        REG_FRAME_LEN:  frame_len_q  <= set_data_i[CNT_W-1:0];
        REG_GAP_LEN:    gap_len_q    <= set_data_i[CNT_W-1:0];
        REG_OFFSET:     offset_q     <= set_data_i[CNT_W-1:0];
        REG_MAX_FRAMES: max_frames_q <= set_data_i[7:0];
        REG_LANE_MASK:  lane_mask_q  <= set_data_i[NUM_CH-1:0];
        default: ;
      endcase
    end
  end

  // Working copies frozen for the duration of a burst; captured on the trigger
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_frame_len_q  <= CNT_W'(DEF_FRAME_LEN);
      sh_gap_len_q    <= CNT_W'(DEF_GAP_LEN);
      sh_offset_q     <= CNT_W'(DEF_OFFSET);
      sh_max_frames_q <= 8'(DEF_MAX_FRAMES);
      sh_lane_mask_q  <= '1;
    end else if (load_i) begin
      sh_frame_len_q  <= frame_len_q;
      sh_gap_len_q    <= gap_len_q;
      sh_offset_q     <= offset_q;
      sh_max_frames_q <= max_frames_q;
      sh_lane_mask_q  <= lane_mask_q;
    end
  end

  assign frame_len_o     = frame_len_q;
  assign gap_len_o       = gap_len_q;
  assign offset_o        = offset_q;
  assign max_frames_o    = max_frames_q;
  assign lane_mask_o     = lane_mask_q;
  assign sh_frame_len_o  = sh_frame_len_q;
  assign sh_gap_len_o    = sh_gap_len_q;
  assign sh_offset_o     = sh_offset_q;
  assign sh_max_frames_o = sh_max_frames_q;
  assign sh_lane_mask_o  = sh_lane_mask_q;

endmodule

// File: rtl/periodic_framer_mc.sv
// Multi-lane periodic framer: trigger-started bursts of fixed-length frames.
module periodic_framer_mc
  import periodic_framer_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned CNT_W   = 16,
  parameter logic [7:0]  SR_BASE = 8'h10
) (
  input  logic                    ce_clk,
  input  logic                    ce_rst_n,
  input  logic                    set_stb,
  input  logic [7:0]              set_addr,
  input  logic [31:0]             set_data,
  input  logic [NUM_CH*WIDTH-1:0] i_tdata,
  input  logic                    i_tuser,
  input  logic                    i_tvalid,
  output logic                    i_tready,
  output logic [NUM_CH*WIDTH-1:0] o_tdata,
  output logic                    o_tlast,
  output logic [7:0]              o_tuser,
  output logic                    o_eob,
  output logic                    o_tvalid,
  input  logic                    o_tready,
  output logic                    busy,
  output logic [15:0]             trig_ignored
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // live and shadow settings
  logic [CNT_W-1:0]  lv_flen, lv_gap, lv_off, sh_flen, sh_gap, sh_off;
  logic [7:0]        lv_max, sh_max;
  logic [NUM_CH-1:0] lv_mask, sh_mask;
  logic              abort_stb;

  // FSM and counters
  state_e            state_q, state_d, phase;
  logic [CNT_W-1:0]  cnt_q, cnt_d, phase_cnt;
  logic [7:0]        frame_cnt_q, frame_cnt_d, frame_inc;
  logic              abort_pend_q, abort_pend_d, abort_eff;
  logic [15:0]       trig_ign_q;

  // settings in force for the current beat
  logic [CNT_W-1:0]  cur_flen, cur_gap, cur_off, flen_m1, gap_m1, off_m1;
  logic [7:0]        cur_max;
  logic [NUM_CH-1:0] cur_mask;

  logic              beat, is_idle, trig_load;
  logic              fwd, fwd_last, fwd_eob;
  logic [NUM_CH-1:0][WIDTH-1:0] lane_in, lane_out;

  // output register
  logic                    o_tvalid_q, o_tlast_q, o_eob_q;
  logic [NUM_CH*WIDTH-1:0] o_tdata_q;
  logic [7:0]              o_tuser_q;

  framer_settings_regs #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .SR_BASE (SR_BASE)
  ) u_regs (
    .clk_i           (ce_clk),
    .rst_ni          (ce_rst_n),
    .set_stb_i       (set_stb),
    .set_addr_i      (set_addr),
    .set_data_i      (set_data),
    .load_i          (trig_load),
    .frame_len_o     (lv_flen),
    .gap_len_o       (lv_gap),
    .offset_o        (lv_off),
    .max_frames_o    (lv_max),
    .lane_mask_o     (lv_mask),
    .sh_frame_len_o  (sh_flen),
    .sh_gap_len_o    (sh_gap),
    .sh_offset_o     (sh_off),
    .sh_max_frames_o (sh_max),
    .sh_lane_mask_o  (sh_mask),
    .abort_o         (abort_stb)
  );

  assign i_tready  = !o_tvalid_q || o_tready;
  assign beat      = i_tvalid && i_tready;
  assign is_idle   = (state_q == IDLE);
  assign trig_load = is_idle && beat && i_tuser;

  // The trigger beat itself is framed with the live values the shadows are
  // about to capture; every later beat uses the shadows.
  assign cur_flen = is_idle ? lv_flen : sh_flen;
  assign cur_gap  = is_idle ? lv_gap  : sh_gap;
  assign cur_off  = is_idle ? lv_off  : sh_off;
  assign cur_max  = is_idle ? lv_max  : sh_max;
  assign cur_mask = is_idle ? lv_mask : sh_mask;

  assign flen_m1 = CNT_W'(len_to_last(16'(cur_flen)));
  assign gap_m1  = cur_gap - ONE;
  assign off_m1  = cur_off - ONE;

  // Trigger beat counts as offset beat 0, or frame beat 0 when offset is 0
  assign phase     = trig_load ? ((cur_off == '0) ? FRAME : OFFSET) : state_q;
  assign phase_cnt = is_idle ? '0 : cnt_q;
  assign abort_eff = !is_idle && (abort_stb || abort_pend_q);
  assign frame_inc = frame_cnt_q + 8'd1;

  // Per-lane masking of forwarded samples
  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    assign lane_in[k]  = i_tdata[k*WIDTH +: WIDTH];
    assign lane_out[k] = cur_mask[k] ? lane_in[k] : '0;
  end

  // FSM state register and counters
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      frame_cnt_q  <= '0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  // Next-state: framing advances only on accepted beats; aborts act at once
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    frame_cnt_d  = frame_cnt_q;
    abort_pend_d = abort_pend_q;
    fwd          = 1'b0;
    fwd_last     = 1'b0;
    fwd_eob      = 1'b0;
    if (abort_stb && (state_q == OFFSET || state_q == GAP)) begin
      state_d     = IDLE;
      cnt_d       = '0;
      frame_cnt_d = '0;
    end else if (beat) begin
      case (phase)
        OFFSET: begin
          if (phase_cnt == off_m1) begin
            state_d = FRAME;
            cnt_d   = '0;
          end else begin
            state_d = OFFSET;
            cnt_d   = phase_cnt + ONE;
          end
        end
        FRAME: begin
          fwd = 1'b1;
          if (phase_cnt == flen_m1 || abort_eff) begin
            fwd_last     = 1'b1;
            cnt_d        = '0;
            abort_pend_d = 1'b0;
            if (abort_eff || (cur_max != '0 && frame_inc == cur_max)) begin
              fwd_eob     = 1'b1;
              state_d     = IDLE;
              frame_cnt_d = '0;
            end else begin
              frame_cnt_d = frame_inc;
              state_d     = (cur_gap == '0) ? FRAME : GAP;
            end
          end else begin
            state_d = FRAME;
            cnt_d   = phase_cnt + ONE;
          end
        end
        GAP: begin
          if (phase_cnt == gap_m1) begin
            state_d = FRAME;
            cnt_d   = '0;
          end else begin
            state_d = GAP;
            cnt_d   = phase_cnt + ONE;
          end
        end
        default: ;
      endcase
    end else if (abort_stb && state_q == FRAME) begin
      abort_pend_d = 1'b1;
    end
  end

  // Saturating count of triggers seen while a burst is already running
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n)
      trig_ign_q <= '0;
    else if (beat && i_tuser && !is_idle && trig_ign_q != 16'hFFFF)
      trig_ign_q <= trig_ign_q + 16'd1;
  end

  // Single output stage; payload only loads on a forwarded beat so it holds
  // steady under backpressure
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      o_tvalid_q <= 1'b0;
      o_tdata_q  <= '0;
      o_tlast_q  <= 1'b0;
      o_tuser_q  <= '0;
      o_eob_q    <= 1'b0;
    end else if (beat && fwd) begin
      o_tvalid_q <= 1'b1;
      o_tdata_q  <= lane_out;
      o_tlast_q  <= fwd_last;
      o_tuser_q  <= frame_cnt_q;
      o_eob_q    <= fwd_eob;
    end else if (o_tready) begin
      o_tvalid_q <= 1'b0;
    end
  end

  assign o_tvalid     = o_tvalid_q;
  assign o_tdata      = o_tdata_q;
  assign o_tlast      = o_tlast_q;
  assign o_tuser      = o_tuser_q;
  assign o_eob        = o_eob_q;
  assign busy         = !is_idle;
  assign trig_ignored = trig_ign_q;

endmodule

// File: doc/periodic_framer_mc.md
# periodic_framer_mc

Multi-lane periodic framer for OFDM receive chains. It follows a Schmidl-Cox style timing detector and turns a continuous sample stream plus a one-beat trigger flag into a burst of fixed-length frames with cyclic prefixes stripped. It generalises the single-channel framer (frame length / gap / offset / max frames) to NUM_CH parallel lanes and parametrised sample width. It adds shadowed settings, per-lane masking, abort, retrigger statistics and a frame-index sideband.

## Interface
- WIDTH, 32: bits per lane sample (complex I/Q packed).
- NUM_CH, 2: lanes carried side by side in one beat; all lanes share one framing.
- CNT_W, 16: width of the length, gap and offset counters.
- SR_BASE, 8'h10: settings base address.
- ce_clk  in  1  clock.
- ce_rst_n  in  1  asynchronous, active-low reset.
- set_stb  in  1  settings write strobe.
- set_addr  in  8  settings address.
- set_data  in  32  settings data.
- i_tdata  in  NUM_CH*WIDTH  input samples; lane k occupies bits [k*WIDTH +: WIDTH].
- i_tuser  in  1  trigger flag on this beat.
- i_tvalid / i_tready  in / out  1  input handshake.
- o_tdata  out  NUM_CH*WIDTH  framed samples.
- o_tlast  out  1  last beat of a frame.
- o_tuser  out  8  frame index within the burst, starting at 0.
- o_eob  out  1  asserted with o_tlast on the final frame of the burst.
- o_tvalid / o_tready  out / in  1  output handshake.
- busy  out  1  state is not IDLE.
- trig_ignored  out  16  saturating count of triggers that arrive while busy.

## Operation
Settings registers, written with set_stb:
- SR_BASE+0 frame_len.
- +1 gap_len.
- +2 offset.
- +3 max_frames (8 bits; 0 means unlimited).
- +4 lane_mask (NUM_CH bits; reset value all ones).
- +5 abort (write of any value).
- Reset values of registers 0 to 3: 64, 16, 0, 1.

Shadowing: on a trigger accepted in IDLE, registers 0 to 4 are copied into working copies. Writes made while busy take effect at the next trigger.

A frame_len of 0 is treated as 1. A gap_len of 0 skips the GAP state.

State machine (advances only on an accepted input beat, i_tvalid && i_tready):
- IDLE: beats are dropped. A beat with i_tuser=1 loads the shadows and is treated as the first OFFSET beat. If offset=0, that trigger beat is instead the first FRAME beat.
- OFFSET: drop `offset` beats counted from the trigger beat, then go to FRAME.
- FRAME: forward frame_len beats. Lanes whose mask bit is 0 are output as zero. o_tlast is set on beat frame_len-1, and frame_cnt increments.
  - If frame_cnt reaches max_frames (non-zero), o_eob is set and the state goes to IDLE.
  - Otherwise the state goes to GAP, or directly to FRAME if gap_len=0.
- GAP: drop gap_len beats, then go to FRAME.

Retrigger: i_tuser=1 while busy is ignored for framing and increments trig_ignored, which saturates at 0xFFFF.

Abort:
- Outside FRAME: return to IDLE immediately.
- In FRAME: the next forwarded beat carries o_tlast=1 and o_eob=1, then the state goes to IDLE.
- An abort in IDLE has no effect.

Simultaneous events: if an abort and a trigger occur in the same cycle while in IDLE, the trigger wins.

## Timing
- The output is a single register stage. Latency from an accepted input beat to o_tvalid is 1 cycle.
- i_tready = !o_tvalid || o_tready, in every state, including dropping states. Backpressure therefore stalls counting.
- o_tvalid falls in the cycle after a handshake unless a new beat loads.
- o_tdata, o_tlast, o_tuser and o_eob are stable while o_tvalid && !o_tready.
- Reset values:
  - All outputs are 0, except i_tready=1.
  - State is IDLE, all counters are 0, trig_ignored is 0.
- Reset applied mid-frame discards the frame. No tlast is emitted.
- Counter arithmetic is CNT_W-bit unsigned compare against (len-1). There is no wrap inside a frame.
- frame_cnt is 8 bits. With unlimited mode it wraps 255 to 0, and o_tuser wraps with it.

## Structure
- Package periodic_framer_pkg holds:
  - the state enum (IDLE, OFFSET, FRAME, GAP);
  - the register offset constants;
  - the reset defaults.
- One sub-module, framer_settings_regs, decodes the settings bus and holds the live and shadow registers. The top level contains the FSM, the counters and the output register.

## Test plan
- Defaults (64 / 16 / 0 / 1), NUM_CH=2, ramp input, trigger on beat 100 -> exactly 64 beats with data 100..163, tlast and eob on beat 163, o_tuser=0, then IDLE.
- Settings 64 / 16 / 20 / 3, trigger at beat 0 -> frames start at beats 20, 100 and 180. o_tuser is 0, 1, 2. eob only on the third tlast. Beats 84..99 and 164..179 are absent from the output.
- Random o_tready at 30% duty with the previous case -> identical output sequence, no duplicates or losses, outputs held stable while stalled.
- Second trigger 10 beats into a burst, plus a write of frame_len=32 while busy -> framing unchanged, trig_ignored=1. The next burst uses 32-beat frames.
- lane_mask=2'b01 -> lane 1 output is zero and lane 0 passes unchanged. max_frames=0 with 300 frames -> o_tuser wraps 255 to 0 and no eob is emitted.
- Abort at frame beat 10 -> beat 10 carries tlast and eob, then IDLE. ce_rst_n low mid-frame -> outputs are 0 immediately, and after release no output until a new trigger.
